// File: rtl/cp0_timer.sv
// Coprocessor-0 for the in-order MIPS core: BadVAddr, Count/Compare timer with
// prescaler, Status, Cause, EPC and PRId. Sits beside the memory stage.
module cp0_timer #(
  parameter int          COUNT_DIV = 2,
  parameter int          HW_INT    = 6,
  parameter logic [31:0] PRID      = 32'h0001_8000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HW_INT-1:0] hint,
  input  logic [7:0]        raddr,
  output logic [31:0]       rdata,
  input  logic              wen,
  input  logic [7:0]        waddr,
  input  logic [31:0]       wdata,
  input  logic              mem_stall,
  input  logic              exp_en,
  input  logic              exp_badvaddr_en,
  input  logic [31:0]       exp_badvaddr,
  input  logic              exp_bd,
  input  logic [4:0]        exp_code,
  input  logic [31:0]       exp_epc,
  input  logic              eret,
  output logic [31:0]       epc_address,
  output logic              allow_interrupt,
  output logic [7:0]        interrupt_flag,
  output logic              timer_int
);

  localparam logic [7:0] A_BADV   = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT  = {5'd9,  3'd0};
  localparam logic [7:0] A_CMP    = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE  = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC    = {5'd14, 3'd0};
  localparam logic [7:0] A_PRID   = {5'd15, 3'd0};
  localparam logic [3:0] DIV_LAST = 4'(COUNT_DIV - 1);

  logic [31:0] badvaddr, count, compare, epc;
  logic [3:0]  presc;
  logic [7:0]  im;
  logic        exl, ie, bd, ti;
  logic [5:0]  hw_ip, hint_ext;
  logic [1:0]  sw_ip;
  logic [4:0]  exc_code;
  logic [7:0]  ip;
  logic [31:0] status_w, cause_w;
  logic        act, tick, take_exc, take_eret;
  logic        wr_count, wr_cmp, wr_status, wr_cause, wr_epc;

  always_comb begin
    hint_ext = '0;
    hint_ext[HW_INT-1:0] = hint;
  end

  assign act       = !mem_stall;
  assign tick      = (presc == DIV_LAST);
  assign take_exc  = act && exp_en;
  assign take_eret = act && eret && !exp_en;
  assign wr_count  = act && wen && (waddr == A_COUNT);
  assign wr_cmp    = act && wen && (waddr == A_CMP);
  assign wr_status = act && wen && (waddr == A_STATUS);
  assign wr_cause  = act && wen && (waddr == A_CAUSE);
  assign wr_epc    = act && wen && (waddr == A_EPC);

  // The timer interrupt folds into the top IP bit alongside the last hw line.
  assign ip       = {hw_ip[5] | ti, hw_ip[4:0], sw_ip};
  assign status_w = {9'd0, 1'b1, 6'd0, im, 5'd0, 1'b0, exl, ie};
  assign cause_w  = {bd, ti, 14'd0, ip, 1'b0, exc_code, 2'd0};

  // Count, prescaler and TI keep running through mem_stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      presc   <= '0;
      compare <= '0;
      ti      <= 1'b0;
      hw_ip   <= '0;
    end else begin
      hw_ip <= hint_ext;
      if (wr_count) begin
        count <= wdata;
        presc <= '0;
      end else begin
        presc <= tick ? 4'd0 : presc + 4'd1;
        if (tick) count <= count + 32'd1;
      end
      if (wr_cmp) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (!wr_count && tick && (count + 32'd1 == compare)) begin
        ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      badvaddr <= '0;
      epc      <= '0;
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      sw_ip    <= '0;
      exc_code <= '0;
    end else begin
      if (wr_status) begin
        im <= wdata[15:8];
        ie <= wdata[0];
      end
      if (wr_cause) sw_ip <= wdata[9:8];
      if (take_exc) begin
        exl      <= 1'b1;
        exc_code <= exp_code;
        // A nested exception keeps the outer restart point.
        if (!exl) begin
          epc <= exp_epc;
          bd  <= exp_bd;
        end
        if (exp_badvaddr_en) badvaddr <= exp_badvaddr;
      end else begin
        if (take_eret)      exl <= 1'b0;
        else if (wr_status) exl <= wdata[1];
        if (wr_epc) epc <= wdata;
      end
    end
  end

  always_comb begin
    case (raddr)
      A_BADV:   rdata = badvaddr;
      A_COUNT:  rdata = count;
      A_CMP:    rdata = compare;
      A_STATUS: rdata = status_w;
      A_CAUSE:  rdata = cause_w;
      A_EPC:    rdata = epc;
      A_PRID:   rdata = PRID;
      default:  rdata = '0;
    endcase
  end

  assign epc_address     = epc;
  assign allow_interrupt = ie && !exl;
  assign interrupt_flag  = im & ip;
  assign timer_int       = ti;

endmodule

// File: tb/tb_cp0_timer.sv
// Self-checking bench for cp0_timer: directed scenarios plus a randomized run
// against an architectural model of the CP0 registers.
module tb_cp0_timer;
  localparam int DIV = 2;
  localparam logic [7:0] R_BADV = 8'h40, R_COUNT = 8'h48, R_CMP = 8'h58,
                         R_STATUS = 8'h60, R_CAUSE = 8'h68, R_EPC = 8'h70,
                         R_PRID = 8'h78;

  logic        clk = 0, rst = 0;
  logic [5:0]  hint = 0;
  logic [7:0]  raddr = 0, waddr = 0;
  logic [31:0] rdata, wdata = 0, exp_badvaddr = 0, exp_epc = 0, epc_address;
  logic        wen = 0, mem_stall = 0, exp_en = 0, exp_badvaddr_en = 0, exp_bd = 0, eret = 0;
  logic [4:0]  exp_code = 0;
  logic        allow_interrupt, timer_int;
  logic [7:0]  interrupt_flag;

  int n_chk = 0, n_fail = 0;

  cp0_timer #(.COUNT_DIV(DIV), .HW_INT(6), .PRID(32'h0001_8000)) dut (
    .clk(clk), .rst(rst), .hint, .raddr(raddr), .rdata(rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata), .mem_stall(mem_stall),
    .exp_en(exp_en), .exp_badvaddr_en(exp_badvaddr_en), .exp_badvaddr(exp_badvaddr),
    .exp_bd(exp_bd), .exp_code(exp_code), .exp_epc(exp_epc), .eret(eret),
    .epc_address(epc_address), .allow_interrupt(allow_interrupt),
    .interrupt_flag(interrupt_flag), .timer_int(timer_int));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  // Architectural model: register contents as the programmer sees them.
  logic [31:0] m_count, m_compare, m_badv, m_epc;
  int          m_since;  // core cycles since Count was last loaded, mod DIV
  logic [7:0]  m_im;
  logic        m_exl, m_ie, m_bd, m_ti;
  logic [5:0]  m_hw;
  logic [1:0]  m_swip;
  logic [4:0]  m_code;

  function automatic void model_reset();
    m_count = 0; m_compare = 0; m_badv = 0; m_epc = 0; m_since = 0;
    m_im = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_hw = 0; m_swip = 0; m_code = 0;
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_swip};
  endfunction

  function automatic logic [31:0] m_read(logic [7:0] a);
    case (a)
      R_BADV:   return m_badv;
      R_COUNT:  return m_count;
      R_CMP:    return m_compare;
      R_STATUS: return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      R_CAUSE:  return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_ip()) << 8) | (32'(m_code) << 2);
      R_EPC:    return m_epc;
      R_PRID:   return 32'h0001_8000;
      default:  return 32'h0;
    endcase
  endfunction

  function automatic void model_step();
    bit act, tick, exc, er, cw, mw, sw, kw, ew, old_exl;
    logic [31:0] old_count, old_cmp;
    act = !mem_stall;
    tick = (m_since == DIV - 1);
    exc = act && exp_en;
    er  = act && eret;
    cw = act && wen && waddr == R_COUNT;
    mw = act && wen && waddr == R_CMP;
    sw = act && wen && waddr == R_STATUS;
    kw = act && wen && waddr == R_CAUSE;
    ew = act && wen && waddr == R_EPC;
    old_exl = m_exl; old_count = m_count; old_cmp = m_compare;
    if (cw) begin m_count = wdata; m_since = 0; end
    else begin
      if (tick) m_count = old_count + 1;
      m_since = (m_since + 1) % DIV;
    end
    if (!cw && tick && old_count + 32'd1 == old_cmp) m_ti = 1;
    if (mw) begin m_compare = wdata; m_ti = 0; end
    m_hw = hint;
    if (sw) begin m_im = wdata[15:8]; m_ie = wdata[0]; end
    if (kw) m_swip = wdata[9:8];
    if (exc) begin
      m_exl = 1; m_code = exp_code;
      if (!old_exl) begin m_epc = exp_epc; m_bd = exp_bd; end
      if (exp_badvaddr_en) m_badv = exp_badvaddr;
    end else if (er) m_exl = 0;
    else if (sw) m_exl = wdata[1];
    if (ew && !exc) m_epc = wdata;
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 0; mem_stall = 0; exp_en = 0; exp_badvaddr_en = 0; eret = 0; exp_bd = 0;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    wen = 1; waddr = a; wdata = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    raddr = R_STATUS; #1;
    n_chk++; if (rdata !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_status got=%h want=%h", rdata, 32'h0040_0000); end
    raddr = R_COUNT; #1;
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_count got=%h want=0", rdata); end
    raddr = R_PRID; #1;
    n_chk++; if (rdata !== 32'h0001_8000) begin n_fail++; $display("FAIL prid got=%h want=00018000", rdata); end
    raddr = 8'h50; #1;
    n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h want=0", rdata); end
    n_chk++;
    if ({epc_address, allow_interrupt, interrupt_flag, timer_int} !== 42'h0) begin
      n_fail++; $display("FAIL reset_outputs epc=%h ai=%b if=%h ti=%b want all 0",
                         epc_address, allow_interrupt, interrupt_flag, timer_int);
    end
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic test_count();
    repeat (10) step();
    raddr = R_COUNT; #1;
    n_chk++; if (rdata !== 32'd5) begin n_fail++; $display("FAIL count_after_10 got=%0d want=5", rdata); end
    mtc0(R_COUNT, 32'd100);
    n_chk++; if (rdata !== 32'd100) begin n_fail++; $display("FAIL count_load got=%0d want=100", rdata); end
    step(); step();
    n_chk++; if (rdata !== 32'd101) begin n_fail++; $display("FAIL count_resume got=%0d want=101", rdata); end
  endtask

  task automatic test_timer();
    bit seen;
    seen = 0;
    mtc0(R_COUNT, 32'd0);
    mtc0(R_CMP, 32'd3);
    mtc0(R_STATUS, 32'h0000_8001);
    raddr = R_COUNT;
    for (int i = 0; i < 12 && !seen; i++) begin
      #1;
      if (rdata == 32'd3) begin
        seen = 1;
        n_chk++; if (timer_int !== 1'b1 || interrupt_flag !== 8'h80) begin
          n_fail++; $display("FAIL timer_match ti=%b if=%h want ti=1 if=80", timer_int, interrupt_flag); end
      end else begin
        n_chk++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL timer_early count=%0d ti=%b want 0", rdata, timer_int); end
        step();
      end
    end
    n_chk++; if (!seen) begin n_fail++; $display("FAIL timer_reach count=%0d want 3 within bound", rdata); end
    mtc0(R_CMP, 32'd50);
    n_chk++; if (timer_int !== 1'b0) begin n_fail++; $display("FAIL compare_clear ti=%b want 0", timer_int); end
    mtc0(R_CMP, 32'd10);
    mtc0(R_COUNT, 32'd9);
    step();
    mtc0(R_CMP, 32'd77);  // tick edge where Count+1 == Compare
    raddr = R_COUNT; #1;
    n_chk++; if (timer_int !== 1'b0 || rdata !== 32'd10) begin
      n_fail++; $display("FAIL match_vs_write ti=%b count=%0d want ti=0 count=10", timer_int, rdata); end
  endtask

  task automatic test_wrap();
    mtc0(R_CMP, 32'd0);
    mtc0(R_COUNT, 32'hFFFF_FFFF);
    step(); step();
    raddr = R_COUNT; #1;
    n_chk++; if (rdata !== 32'd0 || timer_int !== 1'b1) begin
      n_fail++; $display("FAIL wrap count=%h ti=%b want count=0 ti=1", rdata, timer_int); end
  endtask

  task automatic test_nested();
    mtc0(R_STATUS, 32'h0000_0001);
    exp_en = 1; exp_epc = 32'h100; exp_bd = 1; exp_code = 5'd2;
    exp_badvaddr_en = 1; exp_badvaddr = 32'hDEAD_BEEF;
    step(); idle();
    raddr = R_STATUS; #1;
    n_chk++; if (epc_address !== 32'h100 || rdata !== 32'h0040_0003 || allow_interrupt !== 1'b0) begin
      n_fail++; $display("FAIL exc1 epc=%h status=%h ai=%b want 100 00400003 0", epc_address, rdata, allow_interrupt); end
    raddr = R_CAUSE; #1;
    n_chk++; if (rdata[31] !== 1'b1 || rdata[6:2] !== 5'd2) begin
      n_fail++; $display("FAIL exc1_cause bd=%b code=%0d want bd=1 code=2", rdata[31], rdata[6:2]); end
    exp_en = 1; exp_epc = 32'h200; exp_bd = 0; exp_code = 5'd4;
    step(); idle();
    raddr = R_CAUSE; #1;
    n_chk++; if (epc_address !== 32'h100 || rdata[31] !== 1'b1 || rdata[6:2] !== 5'd4) begin
      n_fail++; $display("FAIL exc_nested epc=%h bd=%b code=%0d want 100 1 4", epc_address, rdata[31], rdata[6:2]); end
    raddr = R_BADV; #1;
    n_chk++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL badvaddr got=%h want=deadbeef", rdata); end
    eret = 1;
    step(); idle();
    raddr = R_STATUS; #1;
    n_chk++; if (rdata !== 32'h0040_0001 || allow_interrupt !== 1'b1) begin
      n_fail++; $display("FAIL eret status=%h ai=%b want 00400001 1", rdata, allow_interrupt); end
  endtask

  task automatic test_stall();
    logic [31:0] pre;
    pre = m_count;
    mem_stall = 1; wen = 1; waddr = R_EPC; wdata = 32'h555;
    exp_en = 1; exp_epc = 32'h999; exp_code = 5'd9; hint = 6'b000100;
    step(); step();
    idle();
    raddr = R_COUNT; #1;
    n_chk++; if (rdata !== pre + 32'd1) begin n_fail++; $display("FAIL stall_count got=%h want=%h", rdata, pre + 32'd1); end
    raddr = R_STATUS; #1;
    n_chk++; if (rdata !== 32'h0040_0001 || epc_address !== 32'h100) begin
      n_fail++; $display("FAIL stall_hold status=%h epc=%h want 00400001 100", rdata, epc_address); end
    raddr = R_CAUSE; #1;
    n_chk++; if (rdata[6:2] !== 5'd4 || rdata[12] !== 1'b1) begin
      n_fail++; $display("FAIL stall_cause code=%0d ip12=%b want 4 1", rdata[6:2], rdata[12]); end
    hint = 0;
  endtask

  task automatic test_async_reset();
    mtc0(R_STATUS, 32'h0000_FF01);
    raddr = R_COUNT;
    #2 rst = 0;
    model_reset();
    #1;
    n_chk++; if (rdata !== 32'h0 || {epc_address, allow_interrupt, interrupt_flag, timer_int} !== 42'h0) begin
      n_fail++; $display("FAIL async_reset count=%h epc=%h ai=%b if=%h ti=%b want all 0",
                         rdata, epc_address, allow_interrupt, interrupt_flag, timer_int); end
    raddr = R_STATUS; #1;
    n_chk++; if (rdata !== 32'h0040_0000) begin n_fail++; $display("FAIL async_status got=%h want=00400000", rdata); end
    @(posedge clk); #1;
    rst = 1;
    repeat (4) step();
    raddr = R_COUNT; #1;
    n_chk++; if (rdata !== 32'd2) begin n_fail++; $display("FAIL resume_count got=%0d want=2", rdata); end
  endtask

  task automatic test_random();
    logic [7:0] amap [8];
    amap = '{R_BADV, R_COUNT, R_CMP, R_STATUS, R_CAUSE, R_EPC, R_PRID, 8'h08};
    for (int i = 0; i < 400; i++) begin
      mem_stall = ($urandom_range(0, 4) == 0);
      wen = ($urandom_range(0, 2) == 0);
      waddr = amap[$urandom_range(0, 7)];
      wdata = $urandom;
      if (waddr == R_COUNT) wdata = m_compare - 32'($urandom_range(0, 3));
      exp_en = ($urandom_range(0, 9) == 0);
      exp_epc = $urandom; exp_bd = 1'($urandom); exp_code = 5'($urandom);
      exp_badvaddr_en = 1'($urandom); exp_badvaddr = $urandom;
      eret = ($urandom_range(0, 7) == 0);
      hint = 6'($urandom);
      raddr = amap[$urandom_range(0, 7)];
      #1;
      n_chk++; if (rdata !== m_read(raddr)) begin
        n_fail++; $display("FAIL rand_read[%0d] addr=%h got=%h want=%h", i, raddr, rdata, m_read(raddr)); end
      n_chk++;
      if (epc_address !== m_epc || timer_int !== m_ti || allow_interrupt !== (m_ie && !m_exl) ||
          interrupt_flag !== (m_im & m_ip())) begin
        n_fail++; $display("FAIL rand_out[%0d] epc=%h ti=%b ai=%b if=%h want epc=%h ti=%b ai=%b if=%h",
                           i, epc_address, timer_int, allow_interrupt, interrupt_flag,
                           m_epc, m_ti, m_ie && !m_exl, m_im & m_ip());
      end
      step();
    end
    idle();
  endtask

  initial begin
    model_reset();
    #12;
    test_reset();
    test_count();
    test_timer();
    test_wrap();
    test_nested();
    test_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
